// File: rtl/soml_pkg.sv
// Shared constants and encodings for the SOML decoder front end.
package soml_pkg;
  localparam int N_DEF     = 32;
  localparam int Q_DEF     = 16;
  localparam int H_LEN     = 16;
  localparam int Y_LEN     = 8;
  localparam int FRAME_LEN = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PUSH  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_EARLY   = 2'b01,
    ERR_MISSING = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;
endpackage

// File: rtl/soml_sample_buffer.sv
// One-frame sample store: single write port, combinational H and Y read ports.
module soml_sample_buffer
  import soml_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [4:0]   wr_idx,
  input  logic [N-1:0] wr_r,
  input  logic [N-1:0] wr_i,
  input  logic [3:0]   h_idx,
  output logic [N-1:0] h_r,
  output logic [N-1:0] h_i,
  input  logic [2:0]   y_idx,
  output logic [N-1:0] y_r,
  output logic [N-1:0] y_i
);
  logic [N-1:0] mem_r [FRAME_LEN];
  logic [N-1:0] mem_i [FRAME_LEN];
  logic [4:0]   y_addr;

  assign y_addr = 5'(H_LEN) + {2'b00, y_idx};
  assign h_r    = mem_r[{1'b0, h_idx}];
  assign h_i    = mem_i[{1'b0, h_idx}];
  assign y_r    = mem_r[y_addr];
  assign y_i    = mem_i[y_addr];

  // Sample write; contents need no reset since full/wr_idx gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_r;
      mem_i[wr_idx] <= wr_i;
    end
  end
endmodule

// File: rtl/soml_frame_loader.sv
// Buffers one framed H/Y sample set and replays it into the decoder load sequence.
module soml_frame_loader
  import soml_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_r,
  input  logic [N-1:0] s_i,
  input  logic         s_last,
  output logic         start,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         dec_output_valid,
  output logic         busy,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic [15:0]  frame_cnt
);
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_END    = TW'(TIMEOUT - 1);
  localparam logic [4:0]    LAST_IDX = 5'(FRAME_LEN - 1);
  localparam logic [3:0]    P_END    = 4'(H_LEN - 1);
  localparam logic [3:0]    Y_END    = 4'(Y_LEN - 1);

  state_t        state;
  logic [4:0]    wr_idx;
  logic          full;
  logic [3:0]    p;
  logic [TW-1:0] timer;

  logic          acc, at_last, set_full, fr_err, expire, done, tmo_err, have_frame;
  logic [3:0]    rd_idx;
  logic [N-1:0]  h_r, h_i, y_r, y_i;

  assign s_ready    = !full && !rst;
  assign acc        = s_valid && s_ready;
  assign at_last    = (wr_idx == LAST_IDX);
  assign set_full   = acc && at_last && s_last;
  assign fr_err     = acc && (at_last ? !s_last : s_last);
  assign expire     = (state == ST_WAIT) && (timer == T_END);
  assign done       = (state == ST_WAIT) && dec_output_valid;
  // Decoder completion wins over a coincident timeout.
  assign tmo_err    = expire && !dec_output_valid;
  // A frame finishing this cycle can be launched immediately.
  assign have_frame = full || set_full;
  // Registered outputs present the word for the next cycle.
  assign rd_idx     = (state == ST_START) ? 4'd0 : p + 4'd1;

  soml_sample_buffer #(.N(N)) u_buf (
    .clk    (clk),
    .wr_en  (acc),
    .wr_idx (wr_idx),
    .wr_r   (s_r),
    .wr_i   (s_i),
    .h_idx  (rd_idx),
    .h_r    (h_r),
    .h_i    (h_i),
    .y_idx  (rd_idx[2:0]),
    .y_r    (y_r),
    .y_i    (y_i)
  );

  // Framing checks, buffer bookkeeping and the decoder load FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_idx     <= '0;
      full       <= 1'b0;
      p          <= '0;
      timer      <= '0;
      start      <= 1'b0;
      H_in_valid <= 1'b0;
      H_in_r     <= '0;
      H_in_i     <= '0;
      Y_in_valid <= 1'b0;
      Y_in_r     <= '0;
      Y_in_i     <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      frame_cnt  <= '0;
    end else begin
      frame_err <= fr_err || tmo_err;
      if (tmo_err)     err_code <= ERR_TIMEOUT;
      else if (fr_err) err_code <= at_last ? ERR_MISSING : ERR_EARLY;

      if (acc) wr_idx <= (at_last || s_last) ? 5'd0 : wr_idx + 5'd1;

      if (set_full) full <= 1'b1;
      else if (state == ST_PUSH && p == P_END) full <= 1'b0;

      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (have_frame) begin
            state <= ST_START;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          state      <= ST_PUSH;
          p          <= '0;
          H_in_valid <= 1'b1;
          H_in_r     <= h_r;
          H_in_i     <= h_i;
          Y_in_valid <= 1'b1;
          Y_in_r     <= y_r;
          Y_in_i     <= y_i;
        end
        ST_PUSH: begin
          if (p == P_END) begin
            state      <= ST_WAIT;
            timer      <= '0;
            H_in_valid <= 1'b0;
            H_in_r     <= '0;
            H_in_i     <= '0;
          end else begin
            p      <= p + 4'd1;
            H_in_r <= h_r;
            H_in_i <= h_i;
          end
          Y_in_valid <= (p < Y_END);
          Y_in_r     <= (p < Y_END) ? y_r : '0;
          Y_in_i     <= (p < Y_END) ? y_i : '0;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (done) frame_cnt <= frame_cnt + 16'd1;
          if (done || expire) begin
            if (have_frame) begin
              state <= ST_START;
              start <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
